// File: rtl/operand_fetch_stage.sv
// Operand fetch: register file, forwarding network, load-use stall.
// Resolved operands leave through a registered valid/ready slot.
module operand_fetch_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int REG_W   = 4,
  parameter int FWD_N   = 2,
  parameter int CTRL_W  = 12
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_W-1:0]        src1_idx,
  input  logic [REG_W-1:0]        src2_idx,
  input  logic [REG_W-1:0]        dest_idx,
  input  logic                    src1_is_dest,
  input  logic                    imm_sel,
  input  logic [DATA_W-1:0]       imm,
  input  logic [CTRL_W-1:0]       ctrl_in,
  input  logic                    wb_en,
  input  logic [REG_W-1:0]        wb_idx,
  input  logic [DATA_W-1:0]       wb_data,
  input  logic [FWD_N-1:0]        fwd_valid,
  input  logic [FWD_N*REG_W-1:0]  fwd_idx,
  input  logic [FWD_N*DATA_W-1:0] fwd_data,
  input  logic                    ld_pending,
  input  logic [REG_W-1:0]        ld_idx,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       op1,
  output logic [DATA_W-1:0]       op2,
  output logic [REG_W-1:0]        out_dest,
  output logic [CTRL_W-1:0]       ctrl_out,
  output logic [15:0]             stall_cnt
);

  logic [DATA_W-1:0] rf [REG_CNT];
  logic [REG_W-1:0]  s1, s2;
  logic [DATA_W-1:0] r1, r2;
  logic              hazard;
  logic              accept;

  // Walk sources oldest to youngest so the lowest index wins.
  always_comb begin
    s1 = src1_is_dest ? dest_idx : src1_idx;
    s2 = src2_idx;
    r1 = rf[s1];
    r2 = rf[s2];
    if (wb_en && wb_idx == s1) r1 = wb_data;
    if (wb_en && wb_idx == s2) r2 = wb_data;
    for (int k = FWD_N - 1; k >= 0; k--) begin
      if (fwd_valid[k] && fwd_idx[k*REG_W +: REG_W] == s1)
        r1 = fwd_data[k*DATA_W +: DATA_W];
      if (fwd_valid[k] && fwd_idx[k*REG_W +: REG_W] == s2)
        r2 = fwd_data[k*DATA_W +: DATA_W];
    end
    if (imm_sel) r2 = imm;
  end

  assign hazard = in_valid & ld_pending &
                  ((ld_idx == s1) | (~imm_sel & (ld_idx == s2)));
  assign in_ready = ~flush & ~hazard & (~out_valid | out_ready);
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[wb_idx] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      out_dest  <= '0;
      ctrl_out  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      op1       <= r1;
      op2       <= r2;
      out_dest  <= dest_idx;
      ctrl_out  <= ctrl_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (hazard && !flush && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule
